mult_div_unit: RTL and testbench

Multi-cycle integer multiply/divide unit with architectural HI/LO registers. It is the sequential companion to the single-cycle ALU in the MIPS datapath and executes mult, multu, div and divu. Operation is radix-2 iterative, one bit per clock, with a start/busy/done handshake toward the control unit. mthi and mtlo write HI/LO directly, and HI/LO are always readable for mfhi/mflo.

---
 rtl/mult_div_unit_pkg.sv | 30 +++
 rtl/mult_div_unit.sv | 160 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit and its control decode.
package mult_div_unit_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // R-type funct codes decoded by ALUControl
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MTHI  = 6'd17;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [5:0] FUNCT_MTLO  = 6'd19;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIV   = 6'd26;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;

  // mult and div are the signed variants (op[0] == 0)
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add LSB-first; divide is restoring shift-subtract MSB-first.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [N-1:0] write_data,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  mdu_state_e     state_q, state_d;
  logic [1:0]     op_q;
  logic           sign_a_q, sign_b_q;
  logic [N-1:0]   a_q, b_q, orig_a_q;
  logic [2*N-1:0] acc_q;
  logic [CntW-1:0] cnt_q;
  logic [N-1:0]   hi_q, lo_q;
  logic           done_q, dbz_q;

  logic last_iter;
  assign last_iter = (cnt_q == CntW'(N - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= MDU_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MDU_IDLE: if (start) state_d = MDU_RUN;
      MDU_RUN:  if (last_iter) state_d = MDU_FIX;
      MDU_FIX:  state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != MDU_IDLE);
  end

  // Operand magnitudes; -2^(N-1) maps onto itself as an unsigned value
  logic         signed_in;
  logic [N-1:0] mag_a, mag_b;
  assign signed_in = op_is_signed(op);
  assign mag_a = (signed_in && inA[N-1]) ? -inA : inA;
  assign mag_b = (signed_in && inB[N-1]) ? -inB : inB;

  // Multiply step: multiplier bits consumed from b_q, product shifts in from the top
  logic [N:0]     mul_sum;
  logic [2*N-1:0] mul_acc_next;
  assign mul_sum      = {1'b0, acc_q[2*N-1:N]} + {1'b0, (b_q[0] ? a_q : {N{1'b0}})};
  assign mul_acc_next = {mul_sum, acc_q[N-1:1]};

  // Divide step: dividend bits leave a_q at the top while quotient bits enter at the bottom
  logic [N:0]   rem_sh, rem_next;
  logic [N+1:0] rem_diff;
  logic         q_bit;
  assign rem_sh   = {acc_q[N-1:0], a_q[N-1]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, b_q};
  assign q_bit    = ~rem_diff[N+1];
  assign rem_next = q_bit ? rem_diff[N:0] : rem_sh;

  // Sign correction and result selection at FIX
  logic           fix_signed, signs_differ, div_zero;
  logic [2*N-1:0] prod;
  logic [N-1:0]   quot, rem, res_hi, res_lo;
  always_comb begin
    fix_signed   = op_is_signed(op_q);
    signs_differ = fix_signed && (sign_a_q ^ sign_b_q);
    div_zero     = (b_q == {N{1'b0}});
    prod         = signs_differ ? -acc_q : acc_q;
    quot         = signs_differ ? -a_q : a_q;
    rem          = (fix_signed && sign_a_q) ? -acc_q[N-1:0] : acc_q[N-1:0];
    if (!op_q[1]) begin
      res_hi = prod[2*N-1:N];
      res_lo = prod[N-1:0];
    end else if (div_zero) begin
      res_hi = orig_a_q;
      res_lo = {N{1'b1}};
    end else begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q     <= MDU_MULT;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      orig_a_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        MDU_IDLE: begin
          if (hi_we) hi_q <= write_data;
          if (lo_we) lo_q <= write_data;
          if (start) begin
            op_q     <= op;
            sign_a_q <= inA[N-1];
            sign_b_q <= inB[N-1];
            a_q      <= mag_a;
            b_q      <= mag_b;
            orig_a_q <= inA;
            acc_q    <= '0;
            cnt_q    <= '0;
            dbz_q    <= 1'b0;
          end
        end
        MDU_RUN: begin
          cnt_q <= cnt_q + CntW'(1);
          if (op_q[1]) begin
            a_q   <= {a_q[N-2:0], q_bit};
            acc_q <= {{(N-1){1'b0}}, rem_next};
          end else begin
            b_q   <= b_q >> 1;
            acc_q <= mul_acc_next;
          end
        end
        MDU_FIX: begin
          hi_q   <= res_hi;
          lo_q   <= res_lo;
          done_q <= 1'b1;
          dbz_q  <= op_q[1] && div_zero;
        end
        default: ;
      endcase
    end
  end

  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; a scoreboard queue is checked by a monitor on every done pulse.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned N = 32;

  logic         clock, reset, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [N-1:0] inA, inB, write_data;
  logic         busy, done, div_by_zero;
  logic [N-1:0] hi, lo;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  mult_div_unit #(.N(N)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .inA        (inA),
    .inB        (inB),
    .hi_we      (hi_we),
    .lo_we      (lo_we),
    .write_data (write_data),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest expected result
  initial begin
    forever begin
      @(negedge clock);
      if (done) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got hi=0x%08h lo=0x%08h with empty scoreboard", hi, lo);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("result_dbz", {31'b0, div_by_zero}, {31'b0, e.dbz});
        end
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] ehi, input logic [N-1:0] elo, input logic edbz,
                       input bit push);
    exp_t e;
    @(negedge clock);
    start = 1'b1;
    op    = o;
    inA   = a;
    inB   = b;
    if (push) begin
      e.hi = ehi; e.lo = elo; e.dbz = edbz;
      sb.push_back(e);
    end
    @(negedge clock);
    start = 1'b0;
    inA   = 32'h5A5A_A5A5;
    inB   = 32'h0F0F_F0F0;
  endtask

  // Called at the negedge after the start edge; returns one cycle after the done pulse
  task automatic wait_done(output int cyc, output int busy_cnt);
    cyc = 0;
    busy_cnt = 0;
    while (!done && cyc < 200) begin
      if (busy) busy_cnt++;
      @(negedge clock);
      cyc++;
    end
    check("done_seen", {31'b0, done}, 32'd1);
    @(negedge clock);
    check("done_pulse_len", {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    int cyc, bcnt;
    reset = 1'b0; start = 1'b0; op = MDU_MULT; inA = '0; inB = '0;
    hi_we = 1'b0; lo_we = 1'b0; write_data = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_dbz", {31'b0, div_by_zero}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);

    // 1: multu max*max; done is 34 edges counting the start edge, busy for 33 cycles
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b1);
    wait_done(cyc, bcnt);
    check("latency_edges_after_start", cyc, 32'd33);
    check("busy_cycles", bcnt, 32'd33);

    // 2: signed and unsigned sign rules
    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    wait_done(cyc, bcnt);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    wait_done(cyc, bcnt);
    issue(MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 1'b1);
    wait_done(cyc, bcnt);

    // 3: divide by zero, then signed overflow clears the flag
    issue(MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done(cyc, bcnt);
    check("dbz_latency", cyc, 32'd33);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    check("dbz_clear_on_start", {31'b0, div_by_zero}, 32'd0);
    wait_done(cyc, bcnt);

    // 4: start and mthi while busy are dropped
    issue(MDU_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
    repeat (3) @(negedge clock);
    start = 1'b1; op = MDU_DIVU; inA = 32'd9; inB = 32'd3;
    hi_we = 1'b1; write_data = 32'h0000_DEAD;
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0;
    check("busy_hi_we_ignored", hi, 32'd0);
    check("busy_still_high", {31'b0, busy}, 32'd1);
    wait_done(cyc, bcnt);
    repeat (3) begin
      @(negedge clock);
      check("no_queued_start", {31'b0, busy}, 32'd0);
    end

    // 5: mtlo in idle, then mthi on the start edge gets overwritten by the result
    @(negedge clock);
    lo_we = 1'b1; write_data = 32'h0000_1234;
    @(negedge clock);
    lo_we = 1'b0;
    check("mtlo_idle_lo", lo, 32'h0000_1234);
    check("mtlo_idle_hi", hi, 32'd0);
    start = 1'b1; op = MDU_MULTU; inA = 32'd2; inB = 32'd3;
    hi_we = 1'b1; write_data = 32'h0000_BEEF;
    sb.push_back('{hi: 32'd0, lo: 32'd6, dbz: 1'b0});
    @(negedge clock);
    start = 1'b0; hi_we = 1'b0; inA = 32'hFFFF_0000; inB = 32'h1234_5678;
    check("mthi_on_start_edge", hi, 32'h0000_BEEF);
    repeat (5) @(negedge clock);
    check("hi_held_in_run", hi, 32'h0000_BEEF);
    check("lo_held_in_run", lo, 32'h0000_1234);
    wait_done(cyc, bcnt);

    // 6: asynchronous reset mid-operation, then a clean mult
    issue(MDU_MULT, 32'd100, 32'd200, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_done", {31'b0, done}, 32'd0);
    check("async_rst_hi", hi, 32'd0);
    check("async_rst_lo", lo, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    issue(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
    wait_done(cyc, bcnt);
    check("post_reset_latency", cyc, 32'd33);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
